// File: rtl/field_scan_if.sv
// Scan bus between field_scan, its metaball sources and the framebuffer.
// master = scanner side, slave = sources/framebuffer side.
interface field_scan_if #(
  parameter int unsigned N_BALLS = 3,
  parameter int unsigned COLS    = 32,
  parameter int unsigned ROWS    = 64
);
  localparam int unsigned NPIX = COLS * ROWS;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  logic                    frame_req;
  logic                    px_stb;
  logic [31:0]             p_x;
  logic [31:0]             p_y;
  logic [N_BALLS-1:0]      src_vld;
  logic [32*N_BALLS-1:0]   src_out;
  logic                    mov_en;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic                    wr_data;
  logic                    busy;
  logic                    frame_done;
  logic                    err;

  modport master (
    input  frame_req, src_vld, src_out,
    output px_stb, p_x, p_y, mov_en, wr_en, wr_addr, wr_data, busy, frame_done, err
  );

  modport slave (
    output frame_req, src_vld, src_out,
    input  px_stb, p_x, p_y, mov_en, wr_en, wr_addr, wr_data, busy, frame_done, err
  );
endinterface

// File: rtl/field_scan.sv
// Metaball field scanner: visits every pixel, gathers all source contributions, writes lit/dark.
// Define SCAN_TIMEOUT_EN to bound the source wait (dark pixel + sticky err on expiry).
module field_scan #(
  parameter int unsigned N_BALLS = 3,
  parameter int unsigned COLS    = 32,
  parameter int unsigned ROWS    = 64,
  parameter logic [31:0] THRESH  = 32'h0000_8000,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         rst,
  field_scan_if.master bus
);

  localparam int unsigned NPIX = COLS * ROWS;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SW   = 32 + $clog2(N_BALLS + 1);
  localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STB   = 3'd1;
  localparam logic [2:0] S_GUARD = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ACC   = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_MOVE  = 3'd6;

  if (N_BALLS < 1 || COLS < 1 || ROWS < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("field_scan: N_BALLS, COLS, ROWS and TIMEOUT must all be >= 1");
  end

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [31:0]   cap_q [N_BALLS];
  logic          cap_en_c;

  logic          px_stb_q;
  logic [31:0]   p_x_q, p_y_q;
  logic          mov_en_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_data_q, wr_data_d;
  logic          busy_q;
  logic          frame_done_q;

  logic          all_vld_c;
  logic [SW-1:0] sum_w_c;
  logic [31:0]   sum_sat_c;
  logic          lit_c;
  logic [AW-1:0] pix_addr_c;

`ifdef SCAN_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q;
  logic          err_set_c;
`endif

  assign all_vld_c  = &bus.src_vld;
  assign pix_addr_c = AW'(32'(row_q) * COLS + 32'(col_q));

  // Wide accumulation so the saturation test sees any carry out of bit 31.
  always_comb begin
    sum_w_c = '0;
    for (int unsigned i = 0; i < N_BALLS; i++) begin
      sum_w_c = sum_w_c + SW'(cap_q[i]);
    end
  end

  assign sum_sat_c = (sum_w_c > SW'(SAT_MAX)) ? SAT_MAX : sum_w_c[31:0];
  assign lit_c     = (sum_sat_c >= THRESH);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    cap_en_c  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef SCAN_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_set_c  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.frame_req) begin
          col_d   = '0;
          row_d   = '0;
          state_d = S_STB;
        end
      end
      S_STB: begin
        state_d = S_GUARD;
      end
      S_GUARD: begin
        // Sources still present the previous pixel's vld here.
`ifdef SCAN_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (all_vld_c) begin
          cap_en_c = 1'b1;
          state_d  = S_ACC;
        end
`ifdef SCAN_TIMEOUT_EN
        else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          err_set_c = 1'b1;
          wr_addr_d = pix_addr_c;
          wr_data_d = 1'b0;
          state_d   = S_WR;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
`endif
      end
      S_ACC: begin
        wr_addr_d = pix_addr_c;
        wr_data_d = lit_c;
        state_d   = S_WR;
      end
      S_WR: begin
        if (col_q != CW'(COLS - 1)) begin
          col_d   = col_q + CW'(1);
          state_d = S_STB;
        end else if (row_q != RW'(ROWS - 1)) begin
          col_d   = '0;
          row_d   = row_q + RW'(1);
          state_d = S_STB;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; each strobe is high exactly while in its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      px_stb_q     <= 1'b0;
      p_x_q        <= '0;
      p_y_q        <= '0;
      mov_en_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      px_stb_q     <= (state_d == S_STB);
      p_x_q        <= 32'(col_d) << 15;
      p_y_q        <= 32'(row_d) << 15;
      mov_en_q     <= (state_d == S_MOVE);
      wr_en_q      <= (state_d == S_WR);
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= (state_d == S_MOVE);
    end
  end

  // Contribution capture on the cycle all sources are valid together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_BALLS; i++) begin
        cap_q[i] <= '0;
      end
    end else if (cap_en_c) begin
      for (int unsigned i = 0; i < N_BALLS; i++) begin
        cap_q[i] <= bus.src_out[32*i +: 32];
      end
    end
  end

`ifdef SCAN_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_q | err_set_c;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.px_stb     = px_stb_q;
  assign bus.p_x        = p_x_q;
  assign bus.p_y        = p_y_q;
  assign bus.mov_en     = mov_en_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_field_scan.sv
// Bench for field_scan: reactive source models plus a per-pixel reference (sum, threshold, latency).
`timescale 1ns/1ps
module tb_field_scan;

  localparam int unsigned NB      = 3;
  localparam int unsigned COLS    = 4;
  localparam int unsigned ROWS    = 2;
  localparam int unsigned NPIX    = COLS * ROWS;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] THRESH  = 32'h0000_8000;
  localparam int          NEVER   = 1000;

  logic clk;
  logic rst;

  field_scan_if #(.N_BALLS(NB), .COLS(COLS), .ROWS(ROWS)) bus_if ();

  field_scan #(
    .N_BALLS(NB), .COLS(COLS), .ROWS(ROWS), .THRESH(THRESH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scenario controls written by the main sequence, read by the source models.
  int          mode;
  logic [31:0] fix_val [NB];
  int          fix_dly [NB];

  // Source model and per-pixel expectations.
  int          dly [NB];
  logic [31:0] val [NB];
  int          k   [NB];
  int          cyc, pix_stb, pix_wr, wr_total, mov_total, stb_cyc, exp_lat;
  logic        exp_lit, exp_to, err_exp;
  logic [31:0] stb_px, stb_py;

  function automatic logic [31:0] rand_val();
    case ($urandom_range(3))
      0:       return 32'($urandom_range(32'h4000));
      1:       return 32'hFFFF_0000 | 32'($urandom_range(32'hFFFF));
      2:       return 32'($urandom);
      default: return 32'($urandom_range(32'h3000, 32'h2800));
    endcase
  endfunction

  // Monitor + sources, all on the falling edge.
  initial begin
    cyc = 0; pix_stb = 0; pix_wr = 0; wr_total = 0; mov_total = 0;
    stb_cyc = 0; exp_lat = 0; exp_lit = 1'b0; exp_to = 1'b0; err_exp = 1'b0;
    stb_px = '0; stb_py = '0;
    for (int i = 0; i < NB; i++) begin k[i] = -1; dly[i] = 1; val[i] = '0; end
    bus_if.src_vld = '0;
    bus_if.src_out = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pix_stb = 0; pix_wr = 0; err_exp = 1'b0;
        for (int i = 0; i < NB; i++) k[i] = -1;
        bus_if.src_vld = '0;
        bus_if.src_out = '0;
      end else begin
        if (bus_if.mov_en || bus_if.frame_done)
          check("done_with_mov", 64'(bus_if.frame_done), 64'(bus_if.mov_en));
        if (bus_if.wr_en) begin
          check("wr_addr", 64'(bus_if.wr_addr), 64'(pix_wr));
          check("wr_data", 64'(bus_if.wr_data), 64'(exp_lit));
          check("latency", 64'(cyc - stb_cyc), 64'(exp_lat));
          check("px_hold", 64'(bus_if.p_x), 64'(stb_px));
          check("py_hold", 64'(bus_if.p_y), 64'(stb_py));
          if (exp_to) err_exp = 1'b1;
          check("err", 64'(bus_if.err), 64'(err_exp));
          pix_wr++;
          wr_total++;
        end
        if (bus_if.mov_en) begin
          check("writes_per_frame", 64'(pix_wr), 64'(NPIX));
          pix_stb = 0; pix_wr = 0;
          mov_total++;
        end
        if (bus_if.px_stb) begin
          longint unsigned sum;
          int dmax;
          check("p_x", 64'(bus_if.p_x), 64'((pix_stb % COLS) * 32768));
          check("p_y", 64'(bus_if.p_y), 64'((pix_stb / COLS) * 32768));
          stb_cyc = cyc; stb_px = bus_if.p_x; stb_py = bus_if.p_y;
          sum = 0; dmax = 0;
          for (int i = 0; i < NB; i++) begin
            if (mode == 0) begin
              dly[i] = fix_dly[i]; val[i] = fix_val[i];
            end else begin
              dly[i] = int'($urandom_range(6, 1)); val[i] = rand_val();
            end
            sum += 64'(val[i]);
            if (dly[i] > dmax) dmax = dly[i];
            k[i] = 0;
          end
          if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
          exp_to = 1'b0;
`ifdef SCAN_TIMEOUT_EN
          exp_to = (dmax > int'(TIMEOUT));
`endif
          exp_lit = !exp_to && (sum >= 64'(THRESH));
          exp_lat = exp_to ? int'(TIMEOUT) + 2 : dmax + 3;
          pix_stb++;
        end else begin
          // Stale vld is kept through the guard cycle, then dropped until fresh.
          for (int i = 0; i < NB; i++) begin
            if (k[i] >= 0) begin
              k[i]++;
              if (k[i] == dly[i] + 1) begin
                bus_if.src_vld[i] = 1'b1;
                bus_if.src_out[32*i +: 32] = val[i];
                k[i] = -1;
              end else if (k[i] >= 2) begin
                bus_if.src_vld[i] = 1'b0;
                bus_if.src_out[32*i +: 32] = 32'($urandom);
              end
            end
          end
        end
      end
    end
  end

  task automatic set_fixed(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                           input int d0, input int d1, input int d2);
    mode = 0;
    fix_val[0] = v0; fix_val[1] = v1; fix_val[2] = v2;
    fix_dly[0] = d0; fix_dly[1] = d1; fix_dly[2] = d2;
  endtask

  task automatic run_frame(input string tag);
    int w0, m0, n;
    w0 = wr_total; m0 = mov_total;
    bus_if.frame_req = 1'b1;
    @(negedge clk);
    bus_if.frame_req = 1'b0;
    check({tag, "_busy"}, 64'(bus_if.busy), 64'(1));
    bus_if.frame_req = 1'b1;
    @(negedge clk);
    bus_if.frame_req = 1'b0;
    n = 0;
    while (mov_total == m0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_time"}, 64'(n < 5000), 64'(1));
    @(negedge clk);
    check({tag, "_idle"}, 64'(bus_if.busy), 64'(0));
    repeat (10) @(negedge clk);
    check({tag, "_writes"}, 64'(wr_total - w0), 64'(NPIX));
    check({tag, "_movs"}, 64'(mov_total - m0), 64'(1));
  endtask

  initial begin
    int w1, m1, n;
    rst = 1'b1;
    bus_if.frame_req = 1'b0;
    set_fixed(32'h3000, 32'h3000, 32'h3000, 1, 1, 1);
    repeat (3) @(negedge clk);
    check("rst_px_stb", 64'(bus_if.px_stb), 64'(0));
    check("rst_mov_en", 64'(bus_if.mov_en), 64'(0));
    check("rst_wr_en", 64'(bus_if.wr_en), 64'(0));
    check("rst_wr_data", 64'(bus_if.wr_data), 64'(0));
    check("rst_wr_addr", 64'(bus_if.wr_addr), 64'(0));
    check("rst_busy", 64'(bus_if.busy), 64'(0));
    check("rst_done", 64'(bus_if.frame_done), 64'(0));
    check("rst_err", 64'(bus_if.err), 64'(0));
    check("rst_p_x", 64'(bus_if.p_x), 64'(0));
    check("rst_p_y", 64'(bus_if.p_y), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_frame("all_lit");
    set_fixed(32'h2000, 32'h2000, 32'h2000, 1, 1, 1);
    run_frame("all_dark");
    set_fixed(32'h3000, 32'h3000, 32'h2000, 1, 1, 1);
    run_frame("exact_thresh");
    set_fixed(32'h3000, 32'h3000, 32'h1FFF, 1, 1, 1);
    run_frame("below_thresh");
    set_fixed(32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 1, 1, 1);
    run_frame("sat_all");
    set_fixed(32'hFFFF_0000, 32'h0001_0000, 32'h0000_2000, 1, 2, 3);
    run_frame("sat_nowrap");
    set_fixed(32'h3000, 32'h3000, 32'h3000, 1, 1, 20);
    run_frame("late_src2");
    set_fixed(32'h3000, 32'h2000, 32'h3000, 5, 1, 3);
    run_frame("staggered");

    mode = 1;
    for (int f = 0; f < 6; f++) run_frame("random");

    // Reset in the middle of a frame.
    set_fixed(32'h3000, 32'h3000, 32'h3000, 1, 1, 1);
    w1 = wr_total;
    bus_if.frame_req = 1'b1;
    @(negedge clk);
    bus_if.frame_req = 1'b0;
    n = 0;
    while (wr_total - w1 < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach", 64'(n < 2000), 64'(1));
    rst = 1'b1;
    w1 = wr_total; m1 = mov_total;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(bus_if.busy), 64'(0));
    check("midrst_addr", 64'(bus_if.wr_addr), 64'(0));
    check("midrst_p_x", 64'(bus_if.p_x), 64'(0));
    repeat (60) @(negedge clk);
    check("midrst_no_wr", 64'(wr_total - w1), 64'(0));
    check("midrst_no_mov", 64'(mov_total - m1), 64'(0));
    run_frame("post_rst");

`ifdef SCAN_TIMEOUT_EN
    set_fixed(32'h3000, 32'h3000, 32'h3000, 1, NEVER, 1);
    run_frame("timeout");
    check("timeout_err", 64'(bus_if.err), 64'(1));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("timeout_err_clr", 64'(bus_if.err), 64'(0));
`else
    check("err_tied", 64'(bus_if.err), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
